// File: rtl/dir_lut_writer.sv
// -----------------------------------------------------------------------------
// dir_lut_writer
//
// Generates a 256-entry, 5-bit two's-complement lookup table and streams it
// into an external table RAM, one entry per accepted write. The entry at
// address {row, col} is round(offset + row*krow + col*kcol). All three
// coefficients are signed Q5.8. The value is built with adders only:
//   - acc_row tracks the value at column 0 of the current row.
//   - acc tracks the value at the current address.
//
// Optional feature (compile-time macro):
//   DIR_LUT_SAT_EN  defined   : the rounded value saturates to [-16, +15].
//                   undefined : the rounded value keeps its 5 LSBs (modular wrap).
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle request to generate a table (honoured in IDLE only)
//   abort    in   one-cycle cancel (LOAD/RUN); wins over start and over the
//                 final write
//   offset   in   [13:0] signed Q5.8, value at address 0
//   krow     in   [13:0] signed Q5.8, increment per row
//   kcol     in   [13:0] signed Q5.8, increment per column
//   busy     out  high from LOAD through the last RUN cycle
//   done     out  one-cycle pulse after address 255 is accepted
//   wr_en    out  write request to the table RAM
//   wr_rdy   in   RAM accepts the write this cycle
//   wr_addr  out  [7:0] {row[3:0], col[3:0]}
//   wr_data  out  [4:0] table entry for wr_addr
//
// Handshake: a write transfers on a rising edge where wr_en and wr_rdy are
// both 1. While wr_en is high and wr_rdy is low, wr_addr and wr_data hold.
// wr_en never drops without a transfer, except on abort or reset.
//
// The FSM state is the internal signal state_q. It is of type state_t.
// -----------------------------------------------------------------------------
module dir_lut_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] offset,
  input  logic [13:0] krow,
  input  logic [13:0] kcol,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  input  logic        wr_rdy,
  output logic [7:0]  wr_addr,
  output logic [4:0]  wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;

  logic        [13:0] offset_q;
  logic        [13:0] krow_q;
  logic        [13:0] kcol_q;
  logic signed [19:0] acc_row;
  logic signed [19:0] acc;
  logic        [3:0]  row_q;
  logic        [3:0]  col_q;

  // Sign-extended coefficients. The widest reachable magnitude is about
  // 8192 * 31 < 2^18. Twenty signed bits therefore never overflow.
  logic signed [19:0] offset_x;
  logic signed [19:0] krow_x;
  logic signed [19:0] kcol_x;
  logic signed [19:0] acc_next_col;
  logic signed [19:0] acc_next_row;
  logic               last_addr;

  assign offset_x     = {{6{offset_q[13]}}, offset_q};
  assign krow_x       = {{6{krow_q[13]}}, krow_q};
  assign kcol_x       = {{6{kcol_q[13]}}, kcol_q};
  assign acc_next_col = acc + kcol_x;
  assign acc_next_row = acc_row + krow_x;
  assign last_addr    = (row_q == 4'hF) && (col_q == 4'hF);
  assign wr_addr      = {row_q, col_q};

  // Round half-up: add 0.5 LSB (128 in Q5.8), then arithmetic shift by 8.
  // Afterwards, reduce the result to 5 bits.
  function automatic logic [4:0] reduce(input logic signed [19:0] a);
`ifdef DIR_LUT_SAT_EN
    if (((a + 20'sd128) >>> 8) > 20'sd15)
      return 5'h0F;
    else if (((a + 20'sd128) >>> 8) < -20'sd16)
      return 5'h10;
    else
      return 5'((a + 20'sd128) >>> 8);
`else
    return 5'((a + 20'sd128) >>> 8);
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= 5'd0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      acc_row  <= 20'sd0;
      acc      <= 20'sd0;
      offset_q <= 14'd0;
      krow_q   <= 14'd0;
      kcol_q   <= 14'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            offset_q <= offset;
            krow_q   <= krow;
            kcol_q   <= kcol;
            busy     <= 1'b1;
            state_q  <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Present address 0 on the first RUN cycle.
            // Its data comes straight from the latched offset.
            acc_row <= offset_x;
            acc     <= offset_x;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            wr_data <= reduce(offset_x);
            wr_en   <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (wr_rdy) begin
            if (last_addr) begin
              wr_en   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else if (col_q != 4'hF) begin
              col_q   <= col_q + 4'd1;
              acc     <= acc_next_col;
              wr_data <= reduce(acc_next_col);
            end else begin
              // Wrap to the next row. Its column-0 value is the old row base
              // plus krow, which also becomes the new running value.
              col_q   <= 4'd0;
              row_q   <= row_q + 4'd1;
              acc_row <= acc_next_row;
              acc     <= acc_next_row;
              wr_data <= reduce(acc_next_row);
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
